// File: rtl/cordic_pkg.sv
// Shared widths, FSM state encoding and sign-extension helper for the CORDIC angle sequencer.
package cordic_pkg;

    localparam int ANGLE_W = 15;
    localparam int FRAC_W  = 14;
    localparam int Z_W     = 16;
    localparam int ITER_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widen a Q1.14 angle (or table entry) into the Q2.14 accumulator format.
    function automatic logic signed [Z_W-1:0] sextAngle(input logic signed [ANGLE_W-1:0] a);
        return {{(Z_W-ANGLE_W){a[ANGLE_W-1]}}, a};
    endfunction

endpackage

// File: rtl/cordic_seq_lut.sv
// Arctangent table: val = floor(atan(2^-addr) * 2^14) in Q1.14; entries past 13 are zero.
module cordic_seq_lut
    import cordic_pkg::*;
(
    input  logic [ITER_W-1:0]         addr,
    output logic signed [ANGLE_W-1:0] val
);

    always_comb begin
        val = '0;
        case (addr)
            4'd0:    val = 15'sd12867;
            4'd1:    val = 15'sd7596;
            4'd2:    val = 15'sd4013;
            4'd3:    val = 15'sd2037;
            4'd4:    val = 15'sd1022;
            4'd5:    val = 15'sd511;
            4'd6:    val = 15'sd255;
            4'd7:    val = 15'sd127;
            4'd8:    val = 15'sd63;
            4'd9:    val = 15'sd31;
            4'd10:   val = 15'sd15;
            4'd11:   val = 15'sd7;
            4'd12:   val = 15'sd3;
            4'd13:   val = 15'sd1;
            default: val = '0;
        endcase
    end

endmodule

// File: rtl/cordic_seq.sv
// CORDIC rotation-mode sequencer: drives an external x/y datapath and tracks the residual angle z.
// Optional residual output z_resid is enabled by defining CORDIC_SEQ_RESID_EN.
module cordic_seq
    import cordic_pkg::*;
#(
    parameter int NITER = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [ANGLE_W-1:0] angle,
    output logic                      dp_load,
    output logic                      dp_step,
    output logic                      dp_dir,
    output logic [ITER_W-1:0]         dp_shift,
`ifdef CORDIC_SEQ_RESID_EN
    output logic signed [Z_W-1:0]     z_resid,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NITER - 1);

    state_t                   state_q, state_d;
    logic signed [Z_W-1:0]    z_q, z_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic [ITER_W-1:0]        lutAddr;
    logic signed [ANGLE_W-1:0] lutVal;

    cordic_seq_lut u_lut (
        .addr (lutAddr),
        .val  (lutVal)
    );

    always_comb begin
        state_d   = state_q;
        z_d       = z_q;
        iter_d    = iter_q;
        in_ready  = 1'b0;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        dp_dir    = 1'b0;
        dp_shift  = '0;
        lutAddr   = '0;
        out_valid = 1'b0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dp_load = 1'b1;
                    z_d     = sextAngle(angle);
                    iter_d  = '0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                lutAddr  = iter_q;
                dp_step  = 1'b1;
                dp_shift = iter_q;
                dp_dir   = ~z_q[Z_W-1];
                // Drive z toward zero: subtract the table angle when non-negative, add it otherwise.
                if (!z_q[Z_W-1]) begin
                    z_d = z_q - sextAngle(lutVal);
                end else begin
                    z_d = z_q + sextAngle(lutVal);
                end
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            z_q     <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
        end
    end

`ifdef CORDIC_SEQ_RESID_EN
    assign z_resid = (state_q == ST_DONE) ? z_q : '0;
`endif

endmodule

// File: tb/tb_cordic_seq.sv
// Directed self-checking bench for cordic_seq; expected dp_dir sequences and residuals are hand-derived.
module tb_cordic_seq;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [14:0] angle;
    logic               dp_load;
    logic               dp_step;
    logic               dp_dir;
    logic [3:0]         dp_shift;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
`ifdef CORDIC_SEQ_RESID_EN
    logic signed [15:0] z_resid;
`endif

    int checkCount = 0;
    int errorCount = 0;

    cordic_seq #(.NITER(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle     (angle),
        .dp_load   (dp_load),
        .dp_step   (dp_step),
        .dp_dir    (dp_dir),
        .dp_shift  (dp_shift),
`ifdef CORDIC_SEQ_RESID_EN
        .z_resid   (z_resid),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        int stale;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; angle = '0;
        repeat (2) @(negedge clk);
        #1;
        checkCount++; if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checkCount++; if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checkCount++; if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checkCount++; if ({dp_load, dp_step, dp_dir, dp_shift} !== 7'd0) begin errorCount++; $display("[TB] FAIL reset_dp_outputs: got %0h expected 0", {dp_load, dp_step, dp_dir, dp_shift}); end
        rst_n = 1'b1;
        // Start a job, then pull reset for two cycles in the middle of it.
        @(negedge clk); in_valid = 1'b1; angle = 15'h1000;
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkCount++; if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL midjob_reset_in_ready: got %0b expected 1", in_ready); end
        checkCount++; if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL midjob_reset_busy: got %0b expected 0", busy); end
        checkCount++; if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL midjob_reset_out_valid: got %0b expected 0", out_valid); end
        stale = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (out_valid) stale++;
        end
        out_ready = 1'b0;
        checkCount++; if (stale !== 0) begin errorCount++; $display("[TB] FAIL stale_completion: got %0d out_valid cycles expected 0", stale); end
    endtask

    task automatic test_pi4();
        // z trace for 0x3243: 12867,0,-7596,-3583,-1546,-524,-13,242,115,52,21,6,-1,2 -> final 1
        logic [13:0] expDirs;
        expDirs = 14'b10111110000011;
        @(negedge clk);
        angle = 15'h3243; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        checkCount++; if (dp_load !== 1'b1) begin errorCount++; $display("[TB] FAIL pi4_dp_load: got %0b expected 1", dp_load); end
        checkCount++; if (dp_step !== 1'b0) begin errorCount++; $display("[TB] FAIL pi4_step_cycle0: got %0b expected 0", dp_step); end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checkCount++; if (dp_step !== 1'b1) begin errorCount++; $display("[TB] FAIL pi4_step cycle %0d: got %0b expected 1", i + 1, dp_step); end
            checkCount++; if (dp_shift !== 4'(i)) begin errorCount++; $display("[TB] FAIL pi4_shift cycle %0d: got %0d expected %0d", i + 1, dp_shift, i); end
            checkCount++; if (dp_dir !== expDirs[i]) begin errorCount++; $display("[TB] FAIL pi4_dir cycle %0d: got %0b expected %0b", i + 1, dp_dir, expDirs[i]); end
            checkCount++; if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL pi4_iter_status cycle %0d: got v%0b b%0b r%0b expected v0 b1 r0", i + 1, out_valid, busy, in_ready); end
        end
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL pi4_out_valid_cycle15: got %0b expected 1", out_valid); end
        checkCount++; if ({dp_step, dp_dir, dp_shift} !== 6'd0) begin errorCount++; $display("[TB] FAIL pi4_done_dp_idle: got %0h expected 0", {dp_step, dp_dir, dp_shift}); end
`ifdef CORDIC_SEQ_RESID_EN
        checkCount++; if (z_resid !== 16'sd1) begin errorCount++; $display("[TB] FAIL pi4_z_resid: got %0d expected 1", z_resid); end
`endif
        out_ready = 1'b1;
        @(negedge clk); #1;
        out_ready = 1'b0;
        checkCount++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errorCount++; $display("[TB] FAIL pi4_return_idle: got r%0b v%0b b%0b expected r1 v0 b0", in_ready, out_valid, busy); end
    endtask

    task automatic test_zero();
        int loads, steps;
        logic [1:0] firstDirs;
        loads = 0; steps = 0; firstDirs = 2'b00;
        @(negedge clk);
        angle = 15'h0000; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        if (dp_load) loads++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (dp_load) loads++;
            if (dp_step) begin
                if (steps < 2) firstDirs[steps] = dp_dir;
                steps++;
            end
        end
        checkCount++; if (loads !== 1) begin errorCount++; $display("[TB] FAIL zero_load_pulses: got %0d expected 1", loads); end
        checkCount++; if (steps !== 14) begin errorCount++; $display("[TB] FAIL zero_step_count: got %0d expected 14", steps); end
        checkCount++; if (firstDirs !== 2'b01) begin errorCount++; $display("[TB] FAIL zero_first_dirs: got %0b (second,first) expected 01", firstDirs); end
        checkCount++; if (out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL zero_held_done: got %0b expected 1", out_valid); end
`ifdef CORDIC_SEQ_RESID_EN
        checkCount++; if (z_resid !== 16'sd0) begin errorCount++; $display("[TB] FAIL zero_z_resid: got %0d expected 0", z_resid); end
`endif
        out_ready = 1'b1;
        @(negedge clk); #1;
        out_ready = 1'b0;
        checkCount++; if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL zero_release: got %0b expected 1", in_ready); end
    endtask

    task automatic test_backpressure();
`ifdef CORDIC_SEQ_RESID_EN
        logic signed [15:0] heldResid;
`endif
        int badCycles;
        badCycles = 0;
        @(negedge clk);
        angle = -15'sh3243; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        checkCount++; if (out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_done_reached: got %0b expected 1", out_valid); end
`ifdef CORDIC_SEQ_RESID_EN
        heldResid = z_resid;
        checkCount++; if (!(z_resid >= -16'sd2 && z_resid <= 16'sd2)) begin errorCount++; $display("[TB] FAIL neg_pi4_resid: got %0d expected magnitude <= 2", z_resid); end
`endif
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; angle = 15'h2000;
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dp_load !== 1'b0 || busy !== 1'b1) badCycles++;
`ifdef CORDIC_SEQ_RESID_EN
            if (z_resid !== heldResid) badCycles++;
`endif
            @(negedge clk);
        end
        checkCount++; if (badCycles !== 0) begin errorCount++; $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0", badCycles); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checkCount++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_release_cycle: got v%0b r%0b expected v1 r0", out_valid, in_ready); end
        @(negedge clk); #1;
        out_ready = 1'b0;
        checkCount++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_idle_after: got r%0b v%0b expected r1 v0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        int acceptAt[4];
        int accepts;
        int drainBudget;
        accepts = 0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; angle = 15'h0800;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (dp_load) begin
                if (accepts < 4) acceptAt[accepts] = c;
                accepts++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkCount++; if (accepts !== 4) begin errorCount++; $display("[TB] FAIL b2b_accept_count: got %0d expected 4", accepts); end
        for (int k = 1; k < 4; k++) begin
            if (k < accepts) begin
                checkCount++; if (acceptAt[k] - acceptAt[k-1] !== 16) begin errorCount++; $display("[TB] FAIL b2b_gap %0d: got %0d expected 16", k, acceptAt[k] - acceptAt[k-1]); end
            end
        end
        drainBudget = 40;
        while (!in_ready && drainBudget > 0) begin
            @(negedge clk); #1;
            drainBudget--;
        end
        checkCount++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_drain: got r%0b b%0b expected r1 b0", in_ready, busy); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pi4();
        test_zero();
        test_backpressure();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cordic_seq.md
CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 Parameter: NITER, default 14, number of micro-rotations per job; legal range 1..14.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  job request; angle valid.
REQ-005 Port: in_ready  output  1  sequencer idle, job accepted when in_valid & in_ready.
REQ-006 Port: angle  input  15  signed target angle, radians, 14 fractional bits (Q1.14).
REQ-007 Port: dp_load  output  1  one-cycle pulse; x/y datapath loads its initial vector.
REQ-008 Port: dp_step  output  1  x/y datapath performs one micro-rotation this cycle.
REQ-009 Port: dp_dir  output  1  rotation direction; 1 = positive (z >= 0), 0 = negative.
REQ-010 Port: dp_shift  output  4  shift amount = current iteration index.
REQ-011 Port: out_valid  output  1  job complete; datapath result valid.
REQ-012 Port: out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, ITER, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE: on in_valid, dp_load = 1 combinationally that cycle; z <= sign-extend(angle) to 16 bits; iter <= 0; next state ITER.
REQ-016 ITER: lut address = iter; dp_step = 1; dp_shift = iter; dp_dir = ~z[15].
REQ-017 ITER update: if z >= 0 then z <= z - sext(lut_val), else z <= z + sext(lut_val); iter <= iter + 1.
REQ-018 ITER to DONE when iter == NITER-1 (after that cycle's step); otherwise remain in ITER.
REQ-019 DONE: hold until out_ready; on out_ready, next state IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-020 Latency: accept at cycle 0 -> dp_step cycles 1..NITER -> out_valid first asserted at cycle NITER+1 (15 for default).
REQ-021 z accumulator is 16-bit signed, Q2.14; no overflow is possible for any 15-bit input; no saturation logic.
REQ-022 Outside ITER: dp_step = 0, dp_shift = 0, dp_dir = 0, lut address = 0.
REQ-023 in_valid while busy is ignored; angle is sampled only at acceptance.
REQ-024 out_valid held in DONE with out_ready low indefinitely; z and outputs stable.

Reset
REQ-025 rst_n low at a clock edge: state <= IDLE, iter <= 0, z <= 0; all outputs take IDLE values (in_ready = 1, others 0).
REQ-026 Reset mid-ITER or mid-DONE discards the job; no out_valid is produced for it.

Configuration
REQ-027 Macro CORDIC_SEQ_RESID_EN defined: extra output z_resid, 16 bits, equal to z in DONE, 0 elsewhere.
REQ-028 Macro CORDIC_SEQ_RESID_EN undefined: no z_resid port; behaviour otherwise identical.

Structure
REQ-029 Package cordic_pkg holds ANGLE_W = 15, FRAC_W = 14, Z_W = 16, ITER_W = 4 and the FSM state enum.
REQ-030 One sub-module: the existing angle table lut (addr[3:0] -> val signed[14:0]), instantiated once, address driven from iter.

Verification
REQ-031 Reset: hold rst_n low 2 cycles mid-job -> next cycle in_ready = 1, busy = 0, out_valid = 0; no stale completion.
REQ-032 angle = 0x3243 (pi/4) -> cycle 1 dp_dir = 1, shift 0; cycle 2 dp_dir = 1 (z = 0), shift 1; cycle 3 dp_dir = 0 (z = -0x1DAC); out_valid at cycle 15.
REQ-033 angle = 0x0000 -> dp_dir sequence starts 1, 0; dp_load is a single pulse at cycle 0; dp_step is high for exactly 14 cycles.
REQ-034 Backpressure: out_ready = 0 for 10 cycles in DONE -> out_valid is held, in_ready = 0, and a new in_valid is ignored; release -> IDLE the next cycle.
REQ-035 Back-to-back jobs with out_ready = 1 and in_valid = 1 continuously -> accepts 16 cycles apart (NITER = 14).
REQ-036 With CORDIC_SEQ_RESID_EN, angle = -0x3243 -> |z_resid| <= 0x0002 at DONE.
